// File: rtl/blram_arbiter.sv
// blram_arbiter
// Two-port front end for a single-port block RAM. Port A (CPU) normally has
// priority. Port B (loader/debug) is given the memory after STARVE_LIMIT
// consecutive cycles in which it requested and was refused. Grants are
// combinational within the cycle. Read data returns one cycle after the grant,
// through a registered valid flag per port.
//
// Ports
//   clk                       rising-edge clock
//   rst                       asynchronous, active-low reset (0 = reset)
//   a_req/a_we/a_addr/a_wdata port A request: 1 = write, 0 = read
//   a_gnt                     port A accepted this cycle
//   a_rvalid/a_rdata          port A read data; rdata is 0 when rvalid is 0
//   b_*                       same set of signals for port B
//   mem_we/mem_addr/mem_wdata command to the block RAM
//   mem_rdata                 block RAM data, valid one cycle after the address
module blram_arbiter #(
  parameter int SIZE         = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_req,
  input  logic            a_we,
  input  logic [SIZE-1:0] a_addr,
  input  logic [31:0]     a_wdata,
  output logic            a_gnt,
  output logic            a_rvalid,
  output logic [31:0]     a_rdata,
  input  logic            b_req,
  input  logic            b_we,
  input  logic [SIZE-1:0] b_addr,
  input  logic [31:0]     b_wdata,
  output logic            b_gnt,
  output logic            b_rvalid,
  output logic [31:0]     b_rdata,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_reg, starve_cnt_next;
  logic       a_rvalid_reg, b_rvalid_reg;
  logic       b_win;

  // B wins when it is alone, or when it has lost LIMIT times in a row.
  // Grants are gated by rst so nothing reaches the RAM while in reset.
  always_comb begin
    b_win = b_req & (~a_req | (starve_cnt_reg == LIMIT));
    a_gnt = rst & a_req & ~b_win;
    b_gnt = rst & b_win;
  end

  // With no grant, the address/data buses idle on port A's values.
  always_comb begin
    mem_we    = (a_gnt & a_we) | (b_gnt & b_we);
    mem_addr  = b_gnt ? b_addr  : a_addr;
    mem_wdata = b_gnt ? b_wdata : a_wdata;
  end

  // Loss counter: counts refused B requests; any grant or idle B clears it.
  // The saturation keeps it bounded even though B is forced at LIMIT.
  always_comb begin
    starve_cnt_next = 4'd0;
    if (b_req && !b_gnt) begin
      starve_cnt_next = (starve_cnt_reg == LIMIT) ? LIMIT : starve_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_reg <= 4'd0;
      a_rvalid_reg   <= 1'b0;
      b_rvalid_reg   <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      a_rvalid_reg   <= a_gnt & ~a_we;
      b_rvalid_reg   <= b_gnt & ~b_we;
    end
  end

  // The RAM output is already aligned with the registered valid flags.
  assign a_rvalid = a_rvalid_reg;
  assign b_rvalid = b_rvalid_reg;
  assign a_rdata  = a_rvalid_reg ? mem_rdata : 32'd0;
  assign b_rdata  = b_rvalid_reg ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_blram_arbiter.sv
module tb_blram_arbiter;

  localparam int AW  = 14;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [31:0]   a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0]   a_rdata, b_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  blram_arbiter #(.SIZE(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Block RAM stand-in: registered read, read-before-write.
  logic [31:0] ram [0:(1<<AW)-1] = '{default: 32'd0};
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: contents as seen through completed transfers, plus the
  // read result each port is owed next cycle and B's current losing streak.
  logic [31:0] ref_mem [0:(1<<AW)-1] = '{default: 32'd0};
  logic        m_a_rv, m_b_rv;
  logic [31:0] m_a_rd, m_b_rd;
  int          m_loss;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int obs_loss = 0;
  logic last_a_gnt, last_b_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_a_rv = 1'b0;
    m_b_rv = 1'b0;
    m_loss = 0;
  endtask

  // One clock cycle: inputs are already applied (just after a falling edge).
  task automatic step();
    logic ea, eb;
    #1;
    if (!rst) begin
      ea = 1'b0;
      eb = 1'b0;
    end else begin
      eb = b_req && (!a_req || m_loss >= LIM);
      ea = a_req && !eb;
    end
    check("a_gnt", a_gnt, ea);
    check("b_gnt", b_gnt, eb);
    check("dbl_gnt", a_gnt & b_gnt, 0);
    check("mem_we", mem_we, (ea && a_we) || (eb && b_we));
    if (eb) begin
      check("mem_addr_b", mem_addr, b_addr);
      check("mem_wdata_b", mem_wdata, b_wdata);
    end else begin
      check("mem_addr_a", mem_addr, a_addr);
      check("mem_wdata_a", mem_wdata, a_wdata);
    end
    check("a_rvalid", a_rvalid, m_a_rv);
    check("a_rdata", a_rdata, m_a_rv ? m_a_rd : 32'd0);
    check("b_rvalid", b_rvalid, m_b_rv);
    check("b_rdata", b_rdata, m_b_rv ? m_b_rd : 32'd0);
    if (rst && b_req && !b_gnt) obs_loss++;
    else obs_loss = 0;
    check("b_wait", obs_loss <= LIM, 1);
    last_a_gnt = a_gnt;
    last_b_gnt = b_gnt;
    if (ea) $display("cyc %0d A %s addr=%h wdata=%h", cyc, a_we ? "WR" : "RD", a_addr, a_wdata);
    if (eb) $display("cyc %0d B %s addr=%h wdata=%h", cyc, b_we ? "WR" : "RD", b_addr, b_wdata);
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else begin
      m_a_rv = ea && !a_we;
      if (m_a_rv) m_a_rd = ref_mem[a_addr];
      m_b_rv = eb && !b_we;
      if (m_b_rv) m_b_rd = ref_mem[b_addr];
      if (ea && a_we) ref_mem[a_addr] = a_wdata;
      if (eb && b_we) ref_mem[b_addr] = b_wdata;
      m_loss = (b_req && !eb) ? m_loss + 1 : 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0;
    b_req = 1'b0; b_we = 1'b0;
  endtask

  task automatic set_a(input logic we, input logic [AW-1:0] addr, input logic [31:0] d);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d;
  endtask

  task automatic set_b(input logic we, input logic [AW-1:0] addr, input logic [31:0] d);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, {30'd0, a_gnt, b_gnt}, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_rv"}, {30'd0, a_rvalid, b_rvalid}, 0);
    check({tag, "_rdata"}, a_rdata | b_rdata, 0);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0;
    model_clear();

    // Reset holds everything low even with both ports requesting.
    @(negedge clk);
    set_a(1'b1, 14'h0001, 32'h1111_1111);
    set_b(1'b1, 14'h0002, 32'h2222_2222);
    #1 check_all_zero("rst_hold");
    step();
    step();
    rst = 1'b1;
    idle();

    // Preload through the loader port; first grant right after reset release.
    set_b(1'b1, 14'h0010, 32'hDEAD_BEEF);
    step();
    check("first_gnt", last_b_gnt, 1);
    idle();
    step();

    // A reads 0x0010: grant in N, data in N+1 only.
    set_a(1'b0, 14'h0010, 32'h0);
    step();
    check("rd32_gnt", last_a_gnt, 1);
    idle();
    check("rd32_rvalid", a_rvalid, 1);
    check("rd32_rdata", a_rdata, 32'hDEAD_BEEF);
    step();
    check("rd32_rvalid_drop", a_rvalid, 0);
    check("rd32_rdata_zero", a_rdata, 0);

    // B writes then reads 0x3FFF back to back.
    set_b(1'b1, 14'h3FFF, 32'h1234_5678);
    step();
    check("b33_wr_gnt", last_b_gnt, 1);
    check("b33_wr_norv", b_rvalid, 0);
    set_b(1'b0, 14'h3FFF, 32'h0);
    step();
    check("b33_rd_gnt", last_b_gnt, 1);
    idle();
    check("b33_rvalid", b_rvalid, 1);
    check("b33_rdata", b_rdata, 32'h1234_5678);
    step();

    // Continuous contention: A,A,A,A,B repeating.
    for (int i = 0; i < 15; i++) begin
      set_a(1'b0, 14'(i), 32'h0);
      set_b(1'b0, 14'(i + 100), 32'h0);
      step();
      check("starve_pat", last_b_gnt, (i % 5) == 4);
    end
    idle();
    step();

    // A write and B read of 0x0100 at the same time: A first, B sees new value.
    set_a(1'b1, 14'h0100, 32'hAAAA_5555);
    set_b(1'b0, 14'h0100, 32'h0);
    step();
    check("r35_a_first", last_a_gnt, 1);
    a_req = 1'b0;
    step();
    check("r35_b_gnt", last_b_gnt, 1);
    idle();
    check("r35_rdata", b_rdata, 32'hAAAA_5555);
    step();

    // Reset between a read grant and the next edge: nothing comes back.
    set_a(1'b0, 14'h0010, 32'h0);
    #1 check("mid_gnt", a_gnt, 1);
    rst = 1'b0;
    #1 check_all_zero("mid_rst");
    @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_after");
    idle();
    rst = 1'b1;
    model_clear();
    step();
    check("mid_no_rv", a_rvalid, 0);

    // Reset while rvalid is high drops it immediately.
    set_a(1'b0, 14'h0010, 32'h0);
    step();
    idle();
    check("rv_pre_rst", a_rvalid, 1);
    rst = 1'b0;
    #1 check_all_zero("rv_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    step();

    // A single read completes normally after reset.
    set_a(1'b0, 14'h0010, 32'h0);
    step();
    idle();
    check("post_rst_rdata", a_rdata, 32'hDEAD_BEEF);
    step();

    // Random traffic; requesters hold a request until it is granted.
    last_a_gnt = 1'b0;
    last_b_gnt = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!a_req || last_a_gnt) begin
        a_req   = ($urandom_range(0, 99) < 70);
        a_we    = $urandom_range(0, 1) == 1;
        a_addr  = ($urandom_range(0, 9) < 8) ? 14'($urandom_range(0, 15)) : 14'($urandom_range(0, (1 << AW) - 1));
        a_wdata = $urandom;
      end
      if (!b_req || last_b_gnt) begin
        b_req   = ($urandom_range(0, 99) < 60);
        b_we    = $urandom_range(0, 1) == 1;
        b_addr  = ($urandom_range(0, 9) < 8) ? 14'($urandom_range(0, 15)) : 14'($urandom_range(0, (1 << AW) - 1));
        b_wdata = $urandom;
      end else if ($urandom_range(0, 99) < 3) begin
        b_req = 1'b0;
      end
      step();
    end
    idle();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
